// File: rtl/dmi_echo_if.sv
// DMI write/read handshake bundle between the UART TAP (master) and a DMI target (slave).
interface dmi_echo_if #(
  parameter int WIDTH      = 41,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] write_address;
  logic [WIDTH-1:0]      write_data;
  logic                  write_valid;
  logic                  write_ready;
  logic [ADDR_WIDTH-1:0] read_address;
  logic [WIDTH-1:0]      read_data;
  logic                  read_valid;
  logic                  read_ready;

  modport master (
    output write_address, write_data, write_valid, read_ready,
    input  write_ready, read_address, read_data, read_valid
  );

  modport slave (
    input  write_address, write_data, write_valid, read_ready,
    output write_ready, read_address, read_data, read_valid
  );
endinterface

// File: rtl/dmi_echo_loopback.sv
// DMI loopback target: queues DMI writes in a DEPTH-entry FIFO and echoes them (data ^ XOR_MASK).
// Optional error injection on ERR_ADDR writes is enabled by defining DMI_ECHO_ERR_INJECT_EN.
module dmi_echo_loopback #(
  parameter int                    WIDTH      = 41,
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DEPTH      = 4,
  parameter logic [WIDTH-1:0]      XOR_MASK   = '0,
  parameter logic [ADDR_WIDTH-1:0] ERR_ADDR   = 5'h11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dmi_hard_reset,
  dmi_echo_if.slave                  dmi,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [15:0]                txn_count,
  output logic [1:0]                 dmi_error
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

`ifdef DMI_ECHO_ERR_INJECT_EN
  localparam bit INJECT_EN = 1'b1;
`else
  localparam bit INJECT_EN = 1'b0;
`endif

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [WIDTH-1:0]      data_mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  err_q;

  logic push;
  logic pop;
  logic err_hit;
  logic store;

  // Ready/valid come from registered count only, so no input-to-output paths.
  assign dmi.write_ready  = (count != FULL);
  assign dmi.read_valid   = (count != '0);
  assign dmi.read_address = addr_mem[rd_ptr];
  assign dmi.read_data    = data_mem[rd_ptr] ^ XOR_MASK;

  assign push    = dmi.write_valid && dmi.write_ready;
  assign pop     = dmi.read_valid && dmi.read_ready;
  assign err_hit = INJECT_EN && push && (dmi.write_address == ERR_ADDR);
  assign store   = push && !err_hit;

  assign level     = count;
  assign dmi_error = {err_q, 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      txn_count <= '0;
      err_q     <= 1'b0;
    end else if (dmi_hard_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        txn_count <= txn_count + 16'd1;
      end
      case ({store, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (err_hit) err_q <= 1'b1;
    end
  end

  // Storage needs no reset; entries are only visible while count says so.
  always_ff @(posedge clk) begin
    if (store && !dmi_hard_reset) begin
      addr_mem[wr_ptr] <= dmi.write_address;
      data_mem[wr_ptr] <= dmi.write_data;
    end
  end

endmodule

// File: tb/tb_dmi_echo_loopback.sv
// Directed bench for dmi_echo_loopback: one instance with XOR_MASK 0, one with XOR_MASK 41'h1F.
module tb_dmi_echo_loopback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hard_a = 1'b0;
  logic        hard_b = 1'b0;
  logic [2:0]  level_a, level_b;
  logic [15:0] txn_a, txn_b;
  logic [1:0]  err_a, err_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmi_echo_if #(.WIDTH(41), .ADDR_WIDTH(5)) dmi_a ();
  dmi_echo_if #(.WIDTH(41), .ADDR_WIDTH(5)) dmi_b ();

  dmi_echo_loopback #(.WIDTH(41), .ADDR_WIDTH(5), .DEPTH(4), .XOR_MASK(41'h0)) dut_a (
    .clk(clk), .rst(rst), .dmi_hard_reset(hard_a), .dmi(dmi_a),
    .level(level_a), .txn_count(txn_a), .dmi_error(err_a)
  );

  dmi_echo_loopback #(.WIDTH(41), .ADDR_WIDTH(5), .DEPTH(4), .XOR_MASK(41'h1F)) dut_b (
    .clk(clk), .rst(rst), .dmi_hard_reset(hard_b), .dmi(dmi_b),
    .level(level_b), .txn_count(txn_b), .dmi_error(err_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [4:0] addr, input logic [40:0] data);
    dmi_a.write_address = addr;
    dmi_a.write_data    = data;
    dmi_a.write_valid   = 1'b1;
    step();
    dmi_a.write_valid   = 1'b0;
  endtask

  initial begin
    dmi_a.write_address = '0; dmi_a.write_data = '0; dmi_a.write_valid = 1'b0; dmi_a.read_ready = 1'b0;
    dmi_b.write_address = '0; dmi_b.write_data = '0; dmi_b.write_valid = 1'b0; dmi_b.read_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    chk("rst_level", level_a, 0);
    chk("rst_wready", dmi_a.write_ready, 1);
    chk("rst_rvalid", dmi_a.read_valid, 0);
    chk("rst_txn", txn_a, 0);
    chk("rst_err", err_a, 2'b00);

    // single write / read
    write_a(5'h10, 41'h1_2345_6789);
    chk("one_rvalid", dmi_a.read_valid, 1);
    chk("one_addr", dmi_a.read_address, 5'h10);
    chk("one_data", dmi_a.read_data, 41'h1_2345_6789);
    chk("one_level", level_a, 1);
    dmi_a.read_ready = 1'b1;
    step();
    dmi_a.read_ready = 1'b0;
    chk("one_txn", txn_a, 1);
    chk("one_level_after", level_a, 0);
    chk("one_rvalid_after", dmi_a.read_valid, 0);

    // fill to DEPTH, hold a 5th write, release with one pop
    for (int i = 1; i <= 4; i++) write_a(5'(i), 41'(i));
    chk("full_wready", dmi_a.write_ready, 0);
    chk("full_level", level_a, 4);
    dmi_a.write_address = 5'd5; dmi_a.write_data = 41'd5; dmi_a.write_valid = 1'b1;
    step();
    chk("held_level", level_a, 4);
    chk("held_head", dmi_a.read_data, 41'd1);
    chk("held_head_addr", dmi_a.read_address, 5'd1);
    dmi_a.read_ready = 1'b1;
    step();
    dmi_a.read_ready = 1'b0;
    chk("pop_full_wready", dmi_a.write_ready, 1);
    chk("pop_full_level", level_a, 3);
    step();
    dmi_a.write_valid = 1'b0;
    chk("fifth_level", level_a, 4);
    for (int i = 2; i <= 5; i++) begin
      chk("order_data", dmi_a.read_data, 41'(i));
      chk("order_addr", dmi_a.read_address, 5'(i));
      dmi_a.read_ready = 1'b1;
      step();
      dmi_a.read_ready = 1'b0;
    end
    chk("order_level", level_a, 0);
    chk("order_txn", txn_a, 6);

    // streaming: push and pop every cycle after the first
    dmi_a.read_ready  = 1'b1;
    dmi_a.write_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      dmi_a.write_address = 5'(k);
      dmi_a.write_data    = 41'(1000 + k);
      step();
      chk("stream_level", level_a, 1);
      chk("stream_data", dmi_a.read_data, 41'(1000 + k));
    end
    dmi_a.write_valid = 1'b0;
    step();
    dmi_a.read_ready = 1'b0;
    chk("stream_txn", txn_a, 106);
    chk("stream_level_end", level_a, 0);

    // xor mask on readout
    dmi_b.write_address = 5'h03; dmi_b.write_data = 41'h0; dmi_b.write_valid = 1'b1;
    step();
    dmi_b.write_valid = 1'b0;
    chk("xor_data", dmi_b.read_data, 41'h1F);
    chk("xor_addr", dmi_b.read_address, 5'h03);

    // hard reset with LEVEL 3 and a coincident push
    for (int i = 0; i < 3; i++) write_a(5'h01, 41'(i));
    chk("pre_flush_level", level_a, 3);
    dmi_a.write_address = 5'h02; dmi_a.write_data = 41'h77; dmi_a.write_valid = 1'b1;
    hard_a = 1'b1;
    step();
    hard_a = 1'b0;
    dmi_a.write_valid = 1'b0;
    chk("flush_level", level_a, 0);
    chk("flush_rvalid", dmi_a.read_valid, 0);
    chk("flush_txn", txn_a, 106);
    chk("flush_wready", dmi_a.write_ready, 1);

    // error injection address
    write_a(5'h11, 41'hABC);
`ifdef DMI_ECHO_ERR_INJECT_EN
    chk("inj_level", level_a, 0);
    chk("inj_err", err_a, 2'b10);
`else
    chk("inj_level", level_a, 1);
    chk("inj_err", err_a, 2'b00);
`endif
    write_a(5'h10, 41'hDEF);
`ifdef DMI_ECHO_ERR_INJECT_EN
    chk("inj_next_level", level_a, 1);
    chk("inj_next_data", dmi_a.read_data, 41'hDEF);
    chk("inj_sticky", err_a, 2'b10);
`else
    chk("inj_next_level", level_a, 2);
    chk("inj_next_data", dmi_a.read_data, 41'hABC);
    chk("inj_sticky", err_a, 2'b00);
`endif
    hard_a = 1'b1;
    step();
    hard_a = 1'b0;
    chk("inj_clear_err", err_a, 2'b00);
    chk("inj_clear_level", level_a, 0);

    // async reset mid-transfer discards contents immediately
    write_a(5'h04, 41'h4);
    write_a(5'h05, 41'h5);
    chk("pre_rst_level", level_a, 2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_level", level_a, 0);
    chk("async_rst_rvalid", dmi_a.read_valid, 0);
    chk("async_rst_txn", txn_a, 0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_wready", dmi_a.write_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
